// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice pipeline: field widths, waveform and
// pipeline-phase encodings, the quarter-wave sine table builder and the arithmetic waveforms.
package synth_pkg;

    localparam int PHASE_W  = 10;
    localparam int VOICE_W  = 8;
    localparam int SAMPLE_W = 12;
    localparam int QSINE_N  = 257;

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_SQUARE = 2'd2,
        WAVE_TRI    = 2'd3
    } wave_e;

    typedef enum logic [1:0] {
        PIPE_ST0 = 2'd0,
        PIPE_ST1 = 2'd1,
        PIPE_ST2 = 2'd2
    } pipe_state_e;

    localparam longint PI_FX   = 64'sd843314857;
    localparam int     FX_FRAC = 28;

    // round(2047*sin(2*pi*k/1024)) for k = 0..256, evaluated at elaboration with a
    // Q28 Taylor series; entry 0 ends up in the low bits.
    function automatic logic [QSINE_N*SAMPLE_W-1:0] build_quarter_sine();
        logic [QSINE_N*SAMPLE_W-1:0] tab;
        longint x, x2, term, acc, v;
        tab = '0;
        for (int i = 0; i < QSINE_N; i++) begin
            x    = (PI_FX * longint'(i)) / 512;
            x2   = (x * x) >>> FX_FRAC;
            term = x;
            acc  = x;
            for (int n = 1; n <= 10; n++) begin
                term = -((term * x2) >>> FX_FRAC) / longint'((2 * n) * (2 * n + 1));
                acc  = acc + term;
            end
            v   = (acc * 2047 + (longint'(1) <<< (FX_FRAC - 1))) >>> FX_FRAC;
            tab = {SAMPLE_W'(v), tab[QSINE_N*SAMPLE_W-1:SAMPLE_W]};
        end
        return tab;
    endfunction

    // Non-sine waveforms; sine comes from wave_rom. Triangle t*8-2048 is t*8 with its MSB flipped.
    function automatic logic signed [SAMPLE_W-1:0] calc_wave(input wave_e w,
                                                              input logic [PHASE_W-1:0] p);
        logic [8:0] t;
        t = p[9] ? ~p[8:0] : p[8:0];
        case (w)
            WAVE_SAW:    return {~p[9], p[8:0], 2'b00};
            WAVE_SQUARE: return p[9] ? 12'sh800 : 12'sh7FF;
            WAVE_TRI:    return {~t[8], t[7:0], 3'b000};
            default:     return '0;
        endcase
    endfunction

endpackage

// File: rtl/wave_rom.sv
// 1024 x 12 signed sine ROM with one-cycle synchronous read, stored as a quarter
// wave and unfolded by address symmetry.
module wave_rom
    import synth_pkg::*;
(
    input  logic                       i_clk,
    input  logic [PHASE_W-1:0]         i_addr,
    output logic signed [SAMPLE_W-1:0] o_data
);

    localparam logic [QSINE_N*SAMPLE_W-1:0] QTAB = build_quarter_sine();

    logic [8:0]          qidx;
    logic [11:0]         base;
    logic [SAMPLE_W-1:0] mag;

    always_comb begin
        qidx = i_addr[8] ? (9'd256 - {1'b0, i_addr[7:0]}) : {1'b0, i_addr[7:0]};
        base = {qidx, 3'b000} + {1'b0, qidx, 2'b00};
        mag  = QTAB[base +: SAMPLE_W];
    end

    always_ff @(posedge i_clk) begin
        o_data <= i_addr[9] ? -$signed(mag) : $signed(mag);
    end

endmodule

// File: rtl/voice_mixer.sv
// Three-stage voice mixer: capture (S0), waveform lookup and gating (S1),
// accumulate and emit one mixed sample per frame on the last voice (S2).
module voice_mixer
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 16,
    parameter int WAVE_W     = 12,
    parameter int OUT_W      = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [PHASE_W-1:0]      i_phase,
    input  logic [VOICE_W-1:0]      i_voice_index,
    input  logic [1:0]              i_pipeline_state,
    input  logic [1:0]              i_waveform,
    input  logic                    i_gate_we,
    input  logic [VOICE_W-1:0]      i_gate_voice,
    input  logic                    i_gate_on,
    output logic signed [OUT_W-1:0] o_sample,
    output logic                    o_sample_valid
);

    localparam int SEL_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int GATE_N = 1 << SEL_W;
    localparam logic [VOICE_W-1:0] VOICE_CNT  = VOICE_W'(NUM_VOICES);
    localparam logic [VOICE_W-1:0] LAST_VOICE = VOICE_W'(NUM_VOICES - 1);

    logic [GATE_N-1:0]          gate_q;
    logic                       s0_valid_q, s0_last_q, s0_gate_q;
    wave_e                      s0_wave_q;
    logic [PHASE_W-1:0]         s0_phase_q;
    logic                       s1_valid_q, s1_last_q, s1_gate_q;
    wave_e                      s1_wave_q;
    logic signed [SAMPLE_W-1:0] s1_alt_q;
    logic signed [SAMPLE_W-1:0] rom_data;
    logic signed [WAVE_W-1:0]   s1_value;
    logic signed [OUT_W-1:0]    acc_q, acc_sum_d, sample_q;
    logic                       sample_valid_q;
    logic                       capture;

    wave_rom u_wave_rom (
        .i_clk  (i_clk),
        .i_addr (s0_phase_q),
        .o_data (rom_data)
    );

    assign capture = (i_pipeline_state == PIPE_ST2) && (i_voice_index < VOICE_CNT);

    always_comb begin
        s1_value = '0;
        if (s1_gate_q) begin
            s1_value = (s1_wave_q == WAVE_SINE) ? WAVE_W'(rom_data) : WAVE_W'(s1_alt_q);
        end
    end

    assign acc_sum_d = acc_q + OUT_W'(s1_value);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            gate_q         <= '0;
            s0_valid_q     <= 1'b0;
            s0_last_q      <= 1'b0;
            s0_gate_q      <= 1'b0;
            s0_wave_q      <= WAVE_SINE;
            s0_phase_q     <= '0;
            s1_valid_q     <= 1'b0;
            s1_last_q      <= 1'b0;
            s1_gate_q      <= 1'b0;
            s1_wave_q      <= WAVE_SINE;
            s1_alt_q       <= '0;
            acc_q          <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            // Gate bit is sampled before this cycle's gate write lands.
            s0_valid_q <= capture;
            if (capture) begin
                s0_last_q  <= (i_voice_index == LAST_VOICE);
                s0_gate_q  <= gate_q[i_voice_index[SEL_W-1:0]];
                s0_wave_q  <= wave_e'(i_waveform);
                s0_phase_q <= i_phase;
            end

            s1_valid_q <= s0_valid_q;
            s1_last_q  <= s0_last_q;
            s1_gate_q  <= s0_gate_q;
            s1_wave_q  <= s0_wave_q;
            s1_alt_q   <= calc_wave(s0_wave_q, s0_phase_q);

            sample_valid_q <= 1'b0;
            if (s1_valid_q) begin
                if (s1_last_q) begin
                    sample_q       <= acc_sum_d;
                    sample_valid_q <= 1'b1;
                    acc_q          <= '0;
                end else begin
                    acc_q <= acc_sum_d;
                end
            end

            if (i_gate_we && (i_gate_voice < VOICE_CNT)) begin
                gate_q[i_gate_voice[SEL_W-1:0]] <= i_gate_on;
            end
        end
    end

    assign o_sample       = sample_q;
    assign o_sample_valid = sample_valid_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Bench for voice_mixer: table of single-frame vectors plus hand-written
// gate-race, missing-voice, out-of-range-index and mid-frame-reset sequences.
module tb_voice_mixer;
    import synth_pkg::*;

    localparam int NV = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [9:0]         phase;
    logic [7:0]         vidx;
    logic [1:0]         pst;
    logic [1:0]         wave;
    logic               gwe;
    logic [7:0]         gvoice;
    logic               gon;
    logic signed [15:0] sample;
    logic               valid;

    typedef struct {
        int val;
        int due;
    } exp_t;

    typedef struct {
        string       name;
        logic [1:0]  w;
        logic [15:0] mask;
        int          p0;
        int          po;
        int          exp;
    } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t vecs[13];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic prev_valid = 1'b0;

    voice_mixer #(.NUM_VOICES(16), .WAVE_W(12), .OUT_W(16)) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_phase          (phase),
        .i_voice_index    (vidx),
        .i_pipeline_state (pst),
        .i_waveform       (wave),
        .i_gate_we        (gwe),
        .i_gate_voice     (gvoice),
        .i_gate_on        (gon),
        .o_sample         (sample),
        .o_sample_valid   (valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every valid pulse must match the oldest pending frame, arrive on time and last one cycle.
    always @(negedge clk) begin
        if (valid) begin
            n_checks++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: got sample %0d at cycle %0d, no frame pending",
                         sample, cyc);
            end else begin
                mon_e = sbq.pop_front();
                if (int'(sample) != mon_e.val) begin
                    n_fail++;
                    $display("FAIL sample: got %0d expected %0d", sample, mon_e.val);
                end
                n_checks++;
                if (cyc != mon_e.due) begin
                    n_fail++;
                    $display("FAIL latency: valid at cycle %0d expected cycle %0d", cyc, mon_e.due);
                end
            end
            n_checks++;
            if (prev_valid) begin
                n_fail++;
                $display("FAIL pulse_width: valid high 2 cycles running, expected 1");
            end
        end
        prev_valid = valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic write_gate(input int v, input logic on);
        tick();
        pst = 2'd0; gwe = 1'b1; gvoice = 8'(v); gon = on;
        tick();
        gwe = 1'b0;
    endtask

    task automatic set_gates(input logic [15:0] mask);
        for (int v = 0; v < NV; v++) write_gate(v, mask[v]);
    endtask

    // One producer slot: states 0,1 then capture (state 2) with optional gate write.
    task automatic issue(input int v, input int ph, input bit push, input int e, input bit gw);
        tick();
        pst = 2'd0; gwe = 1'b0;
        tick();
        pst = 2'd1;
        tick();
        pst = 2'd2; vidx = 8'(v); phase = 10'(ph);
        gwe = gw; gvoice = 8'(v); gon = 1'b1;
        if (push) sbq.push_back('{e, cyc + 3});
    endtask

    task automatic finish_frame(input string name);
        tick();
        pst = 2'd0; gwe = 1'b0;
        repeat (6) tick();
        check_eq({name, "_drain"}, sbq.size(), 0);
    endtask

    task automatic run_frame(input string name, input int p0, input int po, input int e);
        for (int v = 0; v < NV; v++) issue(v, (v == 0) ? p0 : po, v == NV - 1, e, 1'b0);
        finish_frame(name);
    endtask

    initial begin
        rst = 1'b1; pst = 2'd0; phase = '0; vidx = '0; wave = WAVE_SINE;
        gwe = 1'b0; gvoice = '0; gon = 1'b0;

        vecs[0]  = '{"sine_peak",     WAVE_SINE,   16'h0001, 256,  0,    2047};
        vecs[1]  = '{"square_pos",    WAVE_SQUARE, 16'hFFFF, 0,    0,    32752};
        vecs[2]  = '{"square_neg",    WAVE_SQUARE, 16'hFFFF, 512,  512,  -32768};
        vecs[3]  = '{"saw_0",         WAVE_SAW,    16'h0001, 0,    0,    -2048};
        vecs[4]  = '{"saw_512",       WAVE_SAW,    16'h0001, 512,  0,    0};
        vecs[5]  = '{"saw_1023",      WAVE_SAW,    16'h0001, 1023, 0,    2044};
        vecs[6]  = '{"tri_0",         WAVE_TRI,    16'h0001, 0,    0,    -2048};
        vecs[7]  = '{"tri_511",       WAVE_TRI,    16'h0001, 511,  0,    2040};
        vecs[8]  = '{"tri_512",       WAVE_TRI,    16'h0001, 512,  0,    2040};
        vecs[9]  = '{"sine_trough",   WAVE_SINE,   16'h0001, 768,  0,    -2047};
        vecs[10] = '{"sine_45deg_x2", WAVE_SINE,   16'h0003, 128,  128,  2894};
        vecs[11] = '{"saw_8voices",   WAVE_SAW,    16'h00FF, 1023, 1023, 16352};
        vecs[12] = '{"tri_all_low",   WAVE_TRI,    16'hFFFF, 0,    1023, -32768};

        repeat (3) tick();
        check_eq("reset_sample", int'(sample), 0);
        check_eq("reset_valid", int'(valid), 0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            set_gates(vecs[i].mask);
            wave = vecs[i].w;
            run_frame(vecs[i].name, vecs[i].p0, vecs[i].po, vecs[i].exp);
        end

        // Gate write racing the capture of voice 3: old (off) value for this frame only.
        set_gates(16'h0001);
        wave = WAVE_SQUARE;
        for (int v = 0; v < NV; v++) issue(v, 0, v == NV - 1, 2047, v == 3);
        finish_frame("gate_race_same");
        for (int v = 0; v < NV; v++) issue(v, 0, v == NV - 1, 4094, 1'b0);
        finish_frame("gate_race_next");

        set_gates(16'hFFFF);
        issue(0, 0, 1'b0, 0, 1'b0);
        issue(5, 0, 1'b0, 0, 1'b0);
        issue(15, 0, 1'b1, 6141, 1'b0);
        finish_frame("missing_voices");

        for (int v = 0; v < NV - 1; v++) issue(v, 0, 1'b0, 0, 1'b0);
        issue(200, 0, 1'b0, 0, 1'b0);
        issue(207, 0, 1'b0, 0, 1'b0);
        issue(15, 0, 1'b1, 32752, 1'b0);
        finish_frame("index_out_of_range");

        // Reset with voice 7 in flight, coinciding with a capture of 15 and a gate write.
        wave = WAVE_SAW;
        set_gates(16'hFFFF);
        for (int v = 0; v < 8; v++) issue(v, 1023, 1'b0, 0, 1'b0);
        tick();
        rst = 1'b1; pst = 2'd2; vidx = 8'd15; phase = 10'd1023;
        gwe = 1'b1; gvoice = 8'd15; gon = 1'b1;
        tick();
        rst = 1'b0; pst = 2'd0; gwe = 1'b0;
        check_eq("midreset_sample", int'(sample), 0);
        check_eq("midreset_valid", int'(valid), 0);
        repeat (6) tick();
        for (int v = 8; v < 15; v++) write_gate(v, 1'b1);
        for (int v = 8; v < NV; v++) issue(v, 1023, v == NV - 1, 14308, 1'b0);
        finish_frame("after_reset");

        check_eq("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/voice_mixer.md
VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 16, number of voices summed per output frame (1..16).
REQ-002 SHALL have parameter WAVE_W, default 12, signed per-voice waveform sample width.
REQ-003 SHALL have parameter OUT_W, default 16, signed mixed output width; OUT_W >= WAVE_W + clog2(NUM_VOICES).
REQ-004 SHALL have i_clk input 1: clock, all logic on rising edge.
REQ-005 SHALL have i_reset input 1: reset, synchronous, active-high.
REQ-006 SHALL have i_phase input 10: phase of current voice from the DDS stage, unsigned.
REQ-007 SHALL have i_voice_index input 8: voice index matching i_phase.
REQ-008 SHALL have i_pipeline_state input 2: shared pipeline phase counter 0,1,2.
REQ-009 SHALL have i_waveform input 2: 0 sine, 1 saw, 2 square, 3 triangle; global.
REQ-010 SHALL have i_gate_we input 1: write strobe for the per-voice gate.
REQ-011 SHALL have i_gate_voice input 8: voice written by i_gate_we.
REQ-012 SHALL have i_gate_on input 1: 1 = note on, 0 = note off.
REQ-013 SHALL have o_sample output OUT_W: signed mixed sample, held between frames.
REQ-014 SHALL have o_sample_valid output 1: one-cycle pulse when o_sample updates.

Function
REQ-015 SHALL capture i_phase, i_voice_index, i_waveform and that voice's gate bit in cycles where i_pipeline_state==2 (stage S0); no capture in other states.
REQ-016 SHALL discard captures with i_voice_index >= NUM_VOICES: no accumulation, no frame end.
REQ-017 S1 (capture+1): SHALL register the waveform value: sine = wave_rom[phase]; saw = {~p[9],p[8:0],2'b00}; square = p[9] ? -2048 : +2047; triangle: t = p[9] ? ~p[8:0] : p[8:0], value = t*8 - 2048 (all WAVE_W=12).
REQ-018 S1 SHALL force the value to 0 when the captured gate bit is 0.
REQ-019 S2 (capture+2): SHALL add the sign-extended value to a running accumulator; no saturation, guaranteed by REQ-003.
REQ-020 S2 for voice NUM_VOICES-1: SHALL set o_sample <= accumulator + value, pulse o_sample_valid for exactly one cycle, clear accumulator to 0 in the same cycle.
REQ-021 Latency: o_sample_valid SHALL be high in the cycle 3 clocks after the S0 capture of voice NUM_VOICES-1.
REQ-022 Gate write: gate[i_gate_voice] <= i_gate_on on i_gate_we; indices >= NUM_VOICES ignored.
REQ-023 Simultaneous gate write and S0 capture of the same voice: SHALL capture the pre-write gate value; new value applies from the next frame.
REQ-024 Stages S0..S2 SHALL be fully pipelined, accepting one capture per cycle even though the producer issues at most one per 3 cycles.
REQ-025 Frames with missing voices SHALL sum only the voices captured; the frame closes only on voice NUM_VOICES-1.

Reset
REQ-026 i_reset SHALL clear: o_sample=0, o_sample_valid=0, accumulator=0, all gate bits=0, all stage valid bits=0.
REQ-027 Reset mid-frame SHALL drop in-flight stages and the partial sum; the first frame after reset contains only voices captured after reset.
REQ-028 i_reset SHALL override S0 capture and gate writes in the same cycle.

Structure
REQ-029 Shared package synth_pkg SHALL hold: waveform select encodings (WAVE_SINE/SAW/SQUARE/TRI), phase width 10, voice index width 8, pipeline state encodings 0/1/2.
REQ-030 Sub-module wave_rom: 1024 x 12 signed synchronous-read ROM, entry k = round(2047*sin(2*pi*k/1024)), 1-cycle read latency aligned with S1.

Verification
REQ-031 Gate voice 0 on, NUM_VOICES=16, sine, voice 0 phase 256, others phase 0 gated off -> one frame, o_sample = +2047, one-cycle valid pulse.
REQ-032 All 16 gated on, square, phase 0 -> o_sample = 16*2047 = 32752; phase 512 -> -32768; no overflow.
REQ-033 Saw, single voice, phase 0/512/1023 -> o_sample = -2048/0/+2044; triangle phase 0/511/512 -> -2048/+2040/+2040.
REQ-034 Gate write on voice 3 in the same cycle as its S0 capture -> that frame excludes it; next frame includes it.
REQ-035 Assert i_reset after voices 0..7 captured -> no valid pulse; the next frame sums only voices 8..15.
REQ-036 Capture with i_voice_index=200 -> accumulator unchanged, no valid pulse.
